// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, state encoding and access legality check
package dmem_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Size/alignment/direction legality only; the address range is checked by the owner of the array.
  function automatic logic access_bad(input logic write, input logic [2:0] funct3,
                                      input logic [1:0] lane);
    case (funct3)
      F3_B:    access_bad = 1'b0;
      F3_H:    access_bad = lane[0];
      F3_W:    access_bad = |lane;
      F3_BU:   access_bad = write;
      F3_HU:   access_bad = write | lane[0];
      default: access_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle of the data-memory port
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_format.sv
// rtl/dmem_lane_format.sv - little-endian byte/half/word store merge and load extract
module dmem_lane_format
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] new_word,
  output logic [31:0] rdata
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    new_word = old_word;
    case (funct3)
      F3_B:    new_word[{lane, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    new_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: new_word = wdata;
    endcase
  end

  always_comb begin
    sel_byte = old_word[{lane, 3'b000} +: 8];
    sel_half = old_word[{lane[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata = {24'h0, sel_byte};
      F3_H:    rdata = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata = {16'h0, sel_half};
      F3_W:    rdata = old_word;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated RV32I data-memory responder with error detection
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             lat_write;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [2:0]       lat_funct3;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             access;
  logic             in_range;
  logic             err;
  logic [AW-1:0]    widx;
  logic [31:0]      old_word;
  logic [31:0]      new_word;
  logic [31:0]      load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid)  state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0)    state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready)  state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.rsp_valid = (state_q == ST_RESP);
    accept        = (state_q == ST_IDLE) && bus.req_valid;
    access        = (state_q == ST_WAIT) && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
    end else if (accept) begin
      cnt_q      <= CNT_W'(WAIT_CYCLES);
      lat_write  <= bus.req_write;
      lat_addr   <= bus.req_addr;
      lat_wdata  <= bus.req_wdata;
      lat_funct3 <= bus.req_funct3;
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign in_range = (lat_addr >> 2) < 32'(DEPTH_WORDS);
  assign err      = access_bad(lat_write, lat_funct3, lat_addr[1:0]) || !in_range;
  assign widx     = lat_addr[AW+1:2];
  assign old_word = mem[widx];

  dmem_lane_format u_lane (
    .old_word (old_word),
    .wdata    (lat_wdata),
    .funct3   (lat_funct3),
    .lane     (lat_addr[1:0]),
    .new_word (new_word),
    .rdata    (load_data)
  );

  // Storage is deliberately unreset; a reset during WAIT never reaches this edge with access high.
  always_ff @(posedge clk) begin
    if (access && lat_write && !err) mem[widx] <= new_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access) begin
      rdata_q <= (err || lat_write) ? 32'h0 : load_data;
      err_q   <= err;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int W_MAIN = 3;
  localparam int D_MAIN = 256;
  localparam int W_ALT  = 0;
  localparam int D_ALT  = 16;

  logic clk;
  logic rst_n;

  logic        sel;
  logic        d_valid;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_f3;
  logic        d_rsp_ready;

  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rdata;
  logic        o_err;

  int checks;
  int errors;

  dmem_responder_if m_if ();
  dmem_responder_if s_if ();

  assign m_if.req_valid  = d_valid & ~sel;
  assign m_if.req_write  = d_write;
  assign m_if.req_addr   = d_addr;
  assign m_if.req_wdata  = d_wdata;
  assign m_if.req_funct3 = d_f3;
  assign m_if.rsp_ready  = d_rsp_ready & ~sel;
  assign s_if.req_valid  = d_valid & sel;
  assign s_if.req_write  = d_write;
  assign s_if.req_addr   = d_addr;
  assign s_if.req_wdata  = d_wdata;
  assign s_if.req_funct3 = d_f3;
  assign s_if.rsp_ready  = d_rsp_ready & sel;

  assign o_req_ready = sel ? s_if.req_ready : m_if.req_ready;
  assign o_rsp_valid = sel ? s_if.rsp_valid : m_if.rsp_valid;
  assign o_rdata     = sel ? s_if.rsp_rdata : m_if.rsp_rdata;
  assign o_err       = sel ? s_if.rsp_err   : m_if.rsp_err;

  dmem_responder #(.DEPTH_WORDS(D_MAIN), .WAIT_CYCLES(W_MAIN)) u_main (
    .clk (clk), .rst_n (rst_n), .bus (m_if)
  );

  dmem_responder #(.DEPTH_WORDS(D_ALT), .WAIT_CYCLES(W_ALT)) u_alt (
    .clk (clk), .rst_n (rst_n), .bus (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  // Byte-addressed reference memory for the main instance.
  logic [7:0] rm [0:4*D_MAIN-1];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.name = nm; v.wr = wr; v.addr = a; v.wdata = wd; v.f3 = f3;
    v.exp_rd = erd; v.exp_err = eerr;
    vt.push_back(v);
  endtask

  function automatic void model(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, input int depth,
                                output logic [31:0] rd, output logic e);
    int sz;
    longint v;
    e  = 1'b0;
    rd = 32'h0;
    sz = 4;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    e = 1'b1;
    endcase
    if (wr && f3 >= 3'd4) e = 1'b1;
    if ((a % sz) != 0) e = 1'b1;
    if ((a / 4) >= depth) e = 1'b1;
    if (e) return;
    if (wr) begin
      for (int i = 0; i < sz; i++) rm[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v + (longint'(rm[int'(a) + i]) << (8 * i));
      if (f3 < 3'd4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      rd = v[31:0];
    end
  endfunction

  task automatic txn(input string nm, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input int exp_lat,
                     output logic [31:0] rd, output logic e);
    int n;
    @(negedge clk);
    d_valid = 1'b1; d_write = wr; d_addr = a; d_wdata = wd; d_f3 = f3; d_rsp_ready = 1'b1;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({nm, "_accept_timeout"}, 32'(n), 32'd0);
    @(posedge clk);
    #1 d_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!o_rsp_valid && n < 50);
    check({nm, "_latency"}, 32'(n), 32'(exp_lat));
    rd = o_rdata;
    e  = o_err;
    @(posedge clk);
    #1 check({nm, "_ready_after_hs"}, {31'h0, o_req_ready}, 32'd1);
  endtask

  logic [31:0] rd, erd;
  logic        e, eerr;
  logic [11:0] rv, rr, exp_rv, exp_rr;
  logic [31:0] b2b_rd0, b2b_rd1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; sel = 1'b0;
    d_valid = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_f3 = '0; d_rsp_ready = 1'b1;

    #1;
    check("rst_req_ready", {31'h0, o_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'h0, o_rsp_valid}, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_err", {31'h0, o_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Store interrupted by reset while waiting must never land.
    @(negedge clk);
    d_valid = 1'b1; d_write = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; d_f3 = 3'd2;
    @(posedge clk);
    #1 d_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rstwait_req_ready", {31'h0, o_req_ready}, 32'd1);
    check("rstwait_rsp_valid", {31'h0, o_rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn("rstwait_lw", 1'b0, 32'h10, 32'h0, 3'd2, W_MAIN + 1, rd, e);
    checks++;
    if (rd === 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rstwait_discard: got %h required not deadbeef", rd);
    end

    add("sw0",       1'b1, 32'h0,        32'h01020304, 3'd2, 32'h0,        1'b0);
    add("sw20",      1'b1, 32'h20,       32'h11223344, 3'd2, 32'h0,        1'b0);
    add("sb21",      1'b1, 32'h21,       32'h000000AA, 3'd0, 32'h0,        1'b0);
    add("lw20",      1'b0, 32'h20,       32'h0,        3'd2, 32'h1122AA44, 1'b0);
    add("lb21",      1'b0, 32'h21,       32'h0,        3'd0, 32'hFFFFFFAA, 1'b0);
    add("lbu21",     1'b0, 32'h21,       32'h0,        3'd4, 32'h000000AA, 1'b0);
    add("sw30",      1'b1, 32'h30,       32'h55556666, 3'd2, 32'h0,        1'b0);
    add("sh32",      1'b1, 32'h32,       32'h00008001, 3'd1, 32'h0,        1'b0);
    add("lh32",      1'b0, 32'h32,       32'h0,        3'd1, 32'hFFFF8001, 1'b0);
    add("lhu32",     1'b0, 32'h32,       32'h0,        3'd5, 32'h00008001, 1'b0);
    add("lw30",      1'b0, 32'h30,       32'h0,        3'd2, 32'h80016666, 1'b0);
    add("lw22_mis",  1'b0, 32'h22,       32'h0,        3'd2, 32'h0,        1'b1);
    add("sh23_mis",  1'b1, 32'h23,       32'h00001234, 3'd1, 32'h0,        1'b1);
    add("f3_011",    1'b0, 32'h20,       32'h0,        3'd3, 32'h0,        1'b1);
    add("sb_oor",    1'b1, 32'h400,      32'h00000077, 3'd0, 32'h0,        1'b1);
    add("sbu_store", 1'b1, 32'h20,       32'h00000099, 3'd4, 32'h0,        1'b1);
    add("lb_oor",    1'b0, 32'h400,      32'h0,        3'd0, 32'h0,        1'b1);
    add("lw_top",    1'b0, 32'hFFFFFFFC, 32'h0,        3'd2, 32'h0,        1'b1);
    add("lw0_keep",  1'b0, 32'h0,        32'h0,        3'd2, 32'h01020304, 1'b0);
    add("lw20_keep", 1'b0, 32'h20,       32'h0,        3'd2, 32'h1122AA44, 1'b0);
    add("lw30_keep", 1'b0, 32'h30,       32'h0,        3'd2, 32'h80016666, 1'b0);

    foreach (vt[i]) begin
      txn(vt[i].name, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].f3, W_MAIN + 1, rd, e);
      check({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
      check({vt[i].name, "_err"}, {31'h0, e}, {31'h0, vt[i].exp_err});
    end

    // Response held while the requester stalls.
    @(negedge clk);
    d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h20; d_f3 = 3'd2; d_rsp_ready = 1'b0;
    @(posedge clk);
    #1 d_valid = 1'b0;
    for (int n = 0; n < 50 && !o_rsp_valid; n++) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", {31'h0, o_rsp_valid}, 32'd1);
      check("hold_rdata", o_rdata, 32'h1122AA44);
      check("hold_req_ready", {31'h0, o_req_ready}, 32'd0);
    end
    d_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_valid", {31'h0, o_rsp_valid}, 32'd0);
    check("hold_release_ready", {31'h0, o_req_ready}, 32'd1);

    // Back-to-back with req_valid held high: store then load of the same word.
    @(negedge clk);
    d_valid = 1'b1; d_write = 1'b1; d_addr = 32'h140; d_wdata = 32'h0BADF00D; d_f3 = 3'd2;
    d_rsp_ready = 1'b1;
    b2b_rd0 = 32'hFFFFFFFF; b2b_rd1 = 32'h0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        d_write = 1'b0; d_wdata = 32'h0;
      end
      rv[k] = o_rsp_valid;
      rr[k] = o_req_ready;
      if (k == W_MAIN + 1) b2b_rd0 = o_rdata;
      if (k == 2 * W_MAIN + 4) b2b_rd1 = o_rdata;
      if (k == W_MAIN + 3) d_valid = 1'b0;
    end
    exp_rv = '0; exp_rr = '0;
    exp_rv[W_MAIN + 1] = 1'b1; exp_rv[2 * W_MAIN + 4] = 1'b1;
    exp_rr[W_MAIN + 2] = 1'b1; exp_rr[2 * W_MAIN + 5] = 1'b1;
    check("b2b_rsp_valid_trace", {20'h0, rv}, {20'h0, exp_rv});
    check("b2b_req_ready_trace", {20'h0, rr}, {20'h0, exp_rr});
    check("b2b_store_rdata", b2b_rd0, 32'h0);
    check("b2b_load_rdata", b2b_rd1, 32'h0BADF00D);

    // Randomized traffic over an initialized window plus occasional wild addresses.
    for (int w = 0; w < 16; w++) begin
      logic [31:0] a, wd;
      a = 32'h100 + 32'(4 * w);
      wd = $urandom;
      model(1'b1, a, wd, 3'd2, D_MAIN, erd, eerr);
      txn("rnd_init", 1'b1, a, wd, 3'd2, W_MAIN + 1, rd, e);
      check("rnd_init_err", {31'h0, e}, {31'h0, eerr});
    end
    for (int it = 0; it < 150; it++) begin
      logic        wr;
      logic [31:0] a, wd;
      logic [2:0]  f3;
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'h100 + 32'($urandom_range(0, 63));
      model(wr, a, wd, f3, D_MAIN, erd, eerr);
      txn("rnd", wr, a, wd, f3, W_MAIN + 1, rd, e);
      check("rnd_rdata", rd, erd);
      check("rnd_err", {31'h0, e}, {31'h0, eerr});
    end

    // Zero-wait instance with a small array.
    sel = 1'b1;
    txn("w0_sw3c", 1'b1, 32'h3C, 32'hCAFEF00D, 3'd2, W_ALT + 1, rd, e);
    check("w0_sw3c_err", {31'h0, e}, 32'd0);
    txn("w0_lw3c", 1'b0, 32'h3C, 32'h0, 3'd2, W_ALT + 1, rd, e);
    check("w0_lw3c_rdata", rd, 32'hCAFEF00D);
    txn("w0_lb3f", 1'b0, 32'h3F, 32'h0, 3'd0, W_ALT + 1, rd, e);
    check("w0_lb3f_rdata", rd, 32'hFFFFFFCA);
    txn("w0_lw40", 1'b0, 32'h40, 32'h0, 3'd2, W_ALT + 1, rd, e);
    check("w0_lw40_err", {31'h0, e}, 32'd1);
    check("w0_lw40_rdata", rd, 32'h0);
    sel = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Handshaked data-memory responder on the core's data-memory port: accepts load/store requests issued by the MEM stage, applies RV32I byte/half/word sizing via funct3, and returns load data or completion after a configurable wait-state count. Enables the pipeline to run against multi-cycle memory and detect misaligned or out-of-range accesses, replacing the single-cycle array model.

## Interface
- DEPTH_WORDS, 256: storage size in 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 2: wait states between accept and response; 0..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_funct3  input  3  RV32I load/store funct3.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes response.
- rsp_rdata  output  32  load result, sign/zero-extended; 0 for stores and errors.
- rsp_err  output  1  access rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. req_valid & req_ready accepts: latch write, addr, wdata, funct3, wait counter := WAIT_CYCLES; go to WAIT.
- WAIT: counter decrements once per cycle; at 0, perform access, register rsp_rdata/rsp_err, go to RESP. WAIT_CYCLES=0 ⇒ exactly one WAIT cycle.
- RESP: rsp_valid=1, outputs stable until rsp_valid & rsp_ready; then IDLE.
- Valid funct3: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only). Others, or 100/101 with req_write, ⇒ error.
- Misaligned (H with addr[0]=1; W with addr[1:0]≠0) ⇒ error.
- Out of range: addr[31:2] ≥ DEPTH_WORDS ⇒ error.
- Error: no write, rsp_rdata=0, rsp_err=1.
- Little-endian. Word index addr[log2(DEPTH_WORDS)+1:2]; byte lane addr[1:0].
- Store: byte-enable merge into addressed word only; other lanes preserved.
- Load: extract lane; B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Memory contents not reset; reads of never-written locations are undefined.

## Timing
- Reset (async assert): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. Deassert is synchronous to clk.
- Accept edge N ⇒ rsp_valid rises after edge N+WAIT_CYCLES+1.
- Store commits at the WAIT→RESP edge; a load issued afterwards observes it.
- Requests not accepted outside IDLE; requester holds req_* stable while req_valid & !req_ready.
- Earliest next accept: edge after the response handshake (req_ready high in the cycle after rsp handshake). Throughput one transaction per WAIT_CYCLES+3 cycles with rsp_ready tied high.
- rsp_ready low in RESP: hold indefinitely, no state change.
- Reset in WAIT: uncommitted store discarded; reset in RESP: response dropped.
- rsp_ready asserted outside RESP: ignored.

## Structure
- Package dmem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, WAIT counter width (4).
- Sub-module dmem_lane_format (combinational): store merge (old word, wdata, funct3, lane → new word) and load extract (word, funct3, lane → rdata). Top holds FSM, counter, request latches, storage array.

## Test plan
- Reset mid-WAIT of SW 0xDEADBEEF @0x10, then LW @0x10 ⇒ value ≠ 0xDEADBEEF unless prior written; req_ready=1, rsp_valid=0 during reset.
- SW 0x11223344 @0x20; SB 0xAA @0x21; LW @0x20 ⇒ 0x1122AA44; LB @0x21 ⇒ 0xFFFFFFAA; LBU @0x21 ⇒ 0x000000AA.
- SH 0x8001 @0x32; LH @0x32 ⇒ 0xFFFF8001; LHU ⇒ 0x00008001; LW @0x30 ⇒ upper half 0x8001.
- LW @0x22, SH @0x23, funct3=011, SB to addr 4·DEPTH_WORDS ⇒ rsp_err=1, rdata=0, target words unchanged.
- WAIT_CYCLES=0 and =3, rsp_ready tied high ⇒ rsp_valid at accept+1 and accept+4 edges; rsp_ready held low 5 cycles ⇒ rsp_valid/rdata stable, req_ready=0.
- Back-to-back req_valid held high ⇒ second accept on edge after first response handshake; no request lost or duplicated.
